// File: rtl/fir_pkg.sv
// Shared definitions for the fir_filter transmit chain.
package fir_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int CLK_DIV_DEF    = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } ser_state_t;

endpackage

// File: rtl/fir_out_serializer_if.sv
// Sample handshake between fir_filter.y_out and the output serializer.
interface fir_out_serializer_if #(
    parameter int DATA_W = fir_pkg::DATA_W_DEF
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/fir_out_serializer_sync_fifo.sv
// Small synchronous FIFO with power-of-two depth and wrapping pointers.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_serializer.sv
// Framed MSB-first serializer for fir_filter output samples.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no frame active; pops the FIFO head as soon as one exists
// S_SHIFT | shifting DATA_W bits, CLK_DIV clk cycles per bit
// S_GAP   | one silent bit period; chains straight into the next frame
module fir_out_serializer
    import fir_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CLK_DIV    = CLK_DIV_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fir_out_serializer_if.slave   in_if,
    input  logic                  clr_ovf,
    output logic                  sclk_o,
    output logic                  sdata_o,
    output logic                  fsync_o,
    output logic                  busy,
    output logic                  overflow
);
    localparam int BW  = $clog2(DATA_W);
    localparam int DVW = $clog2(CLK_DIV);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_W - 1);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(CLK_DIV - 1);
    localparam logic [DVW-1:0] DIV_HALF = DVW'(CLK_DIV / 2);

    ser_state_t                 state;
    logic [DATA_W-1:0]          shift_reg;
    logic [BW-1:0]              bit_cnt;
    logic [DVW-1:0]             div_cnt;
    logic                       live;

    logic                       fifo_push;
    logic                       fifo_pop;
    logic [DATA_W-1:0]          fifo_head;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                       bit_end;

    // live keeps in_ready low while reset is asserted and until the first edge after release.
    assign in_if.in_ready = live && !fifo_full;
    assign fifo_push      = in_if.in_valid && in_if.in_ready;
    assign bit_end        = (div_cnt == DIV_LAST);
    assign fifo_pop       = !fifo_empty &&
                            ((state == S_IDLE) || ((state == S_GAP) && bit_end));

    assign sdata_o  = (state == S_SHIFT) && shift_reg[DATA_W-1];
    assign sclk_o   = (state == S_SHIFT) && (div_cnt >= DIV_HALF);
    assign fsync_o  = (state == S_SHIFT) && (bit_cnt == BIT_LAST);
    assign busy     = (state != S_IDLE) || (fifo_count != '0);

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (in_if.in_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Ready qualifier: becomes 1 on the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) live <= 1'b0;
        else          live <= 1'b1;
    end

    // Sticky drop flag; a new drop in the same cycle as clr_ovf keeps it set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (in_if.in_valid && !in_if.in_ready) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Frame sequencer: bit divider, shift register and IDLE/SHIFT/GAP control.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        shift_reg <= fifo_head;
                        bit_cnt   <= BIT_LAST;
                        div_cnt   <= '0;
                        state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        if (bit_cnt == '0) begin
                            state <= S_GAP;
                        end else begin
                            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                            bit_cnt   <= bit_cnt - 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        if (!fifo_empty) begin
                            shift_reg <= fifo_head;
                            bit_cnt   <= BIT_LAST;
                            state     <= S_SHIFT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_out_serializer.sv
// Directed, table-driven bench for fir_out_serializer at default parameters.
module tb_fir_out_serializer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clr_ovf = 1'b0;
    logic sclk_o, sdata_o, fsync_o, busy, overflow;

    fir_out_serializer_if #(.DATA_W(16)) bus ();

    fir_out_serializer #(
        .DATA_W     (16),
        .FIFO_DEPTH (4),
        .CLK_DIV    (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_if    (bus),
        .clr_ovf  (clr_ovf),
        .sclk_o   (sclk_o),
        .sdata_o  (sdata_o),
        .fsync_o  (fsync_o),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Receiver model: a frame starts on an sclk rise with fsync high.
    logic [15:0] rx_q[$];
    int          fs_q[$];
    logic [15:0] cur = '0;
    int          nbits = 0;
    logic        prev_sclk = 1'b0;
    logic        prev_fs = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            nbits = 0;
            prev_sclk = 1'b0;
            prev_fs = 1'b0;
        end else begin
            if (fsync_o && !prev_fs) fs_q.push_back(cyc);
            if (sclk_o && !prev_sclk) begin
                if (fsync_o) begin
                    cur = {15'b0, sdata_o};
                    nbits = 1;
                end else begin
                    cur = {cur[14:0], sdata_o};
                    nbits++;
                end
                if (nbits == 16) begin
                    rx_q.push_back(cur);
                    nbits = 0;
                end
            end
            prev_sclk = sclk_o;
            prev_fs = fsync_o;
        end
    end

    function automatic logic [31:0] rx_at(input int i);
        if (i < rx_q.size()) return 32'(rx_q[i]);
        return 'x;
    endfunction

    function automatic logic [31:0] fs_gap(input int i);
        if (i < fs_q.size() && i > 0) return 32'(fs_q[i] - fs_q[i-1]);
        return 'x;
    endfunction

    task automatic clear_rx();
        rx_q.delete();
        fs_q.delete();
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        check({name, " idle"}, busy, 1'b0);
    endtask

    // Pushes vals honoring in_ready; first_block is the edge index at which in_ready was first low.
    task automatic push_burst(input logic [15:0] vals[$], output int first_block);
        int n;
        int edge_i;
        n = 0;
        edge_i = 0;
        first_block = -1;
        while (n < vals.size() && edge_i < 2000) begin
            @(negedge clk);
            edge_i++;
            if (bus.in_ready) begin
                bus.in_valid = 1'b1;
                bus.in_data  = vals[n];
                n++;
            end else begin
                bus.in_valid = 1'b0;
                if (first_block < 0) first_block = edge_i;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // One sample written at edge E; k counts edges after E.
    task automatic send_single(input logic [15:0] d, output int fs_start, output int fs_len,
                               output int rises, output int busy_low, output int gap_bad);
        logic prev;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        fs_start = -1; fs_len = 0; rises = 0; busy_low = -1; gap_bad = 0; prev = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (fsync_o) begin
                fs_len++;
                if (fs_start < 0) fs_start = k;
            end
            if (sclk_o && !prev) rises++;
            prev = sclk_o;
            if (k >= 65 && k <= 68 && (sclk_o || sdata_o || fsync_o)) gap_bad++;
            if (!busy && busy_low < 0) busy_low = k;
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic [15:0] exp_word;
        int          exp_fs_start;
        int          exp_fs_len;
        int          exp_rises;
        int          exp_busy_low;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs_start, fs_len, rises, busy_low, gap_bad, fb;
        logic [15:0] vals[$];

        vecs[0] = '{16'h0064, 16'h0064, 1, 4, 16, 69};
        vecs[1] = '{16'h7FFF, 16'h7FFF, 1, 4, 16, 69};
        vecs[2] = '{16'h0001, 16'h0001, 1, 4, 16, 69};
        vecs[3] = '{16'hA5A5, 16'hA5A5, 1, 4, 16, 69};
        vecs[4] = '{16'hFFD8, 16'hFFD8, 1, 4, 16, 69};
        vecs[5] = '{16'h8001, 16'h8001, 1, 4, 16, 69};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset state
        #12;
        check("rst in_ready", bus.in_ready, 1'b0);
        check("rst sclk", sclk_o, 1'b0);
        check("rst sdata", sdata_o, 1'b0);
        check("rst fsync", fsync_o, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst ovf", overflow, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post-rst in_ready", bus.in_ready, 1'b1);
        check("post-rst busy", busy, 1'b0);

        // Single-sample frames (entry 0 is the 100 decimal case)
        for (int i = 0; i < 6; i++) begin
            clear_rx();
            send_single(vecs[i].data, fs_start, fs_len, rises, busy_low, gap_bad);
            check($sformatf("v%0d word", i), rx_at(0), 32'(vecs[i].exp_word));
            check($sformatf("v%0d nframes", i), rx_q.size(), 1);
            check($sformatf("v%0d fsync start", i), fs_start, vecs[i].exp_fs_start);
            check($sformatf("v%0d fsync len", i), fs_len, vecs[i].exp_fs_len);
            check($sformatf("v%0d sclk rises", i), rises, vecs[i].exp_rises);
            check($sformatf("v%0d busy low at", i), busy_low, vecs[i].exp_busy_low);
            check($sformatf("v%0d gap quiet", i), gap_bad, 0);
        end

        // Negative extremes back to back
        clear_rx();
        vals = '{16'hFFFF, 16'h8000};
        push_burst(vals, fb);
        wait_idle(400, "neg");
        check("neg nframes", rx_q.size(), 2);
        check("neg word0", rx_at(0), 32'h0000_FFFF);
        check("neg word1", rx_at(1), 32'h0000_8000);
        check("neg fsync spacing", fs_gap(1), 68);

        // Burst with in_ready honored
        clear_rx();
        vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
        push_burst(vals, fb);
        check("burst first block edge", fb, 6);
        wait_idle(800, "burst");
        check("burst nframes", rx_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("burst word%0d", i), rx_at(i), 32'(16'h1111 * (i + 1)));
            if (i > 0) check($sformatf("burst spacing%0d", i), fs_gap(i), 68);
        end
        check("burst no ovf", overflow, 1'b0);

        // Overflow: in_valid held regardless of in_ready; clr_ovf collides with a drop at edge 7
        clear_rx();
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 16'hA000 + 16'(i);
            clr_ovf      = (i == 7);
            @(posedge clk); #1;
            check($sformatf("ovf after edge%0d", i), overflow, (i >= 6));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        clr_ovf = 1'b0;
        @(posedge clk); #1;
        check("ovf sticky", overflow, 1'b1);
        @(negedge clk);
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        check("ovf cleared", overflow, 1'b0);
        @(negedge clk);
        clr_ovf = 1'b0;
        wait_idle(800, "ovf");
        check("ovf nframes", rx_q.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("ovf word%0d", i), rx_at(i), 32'(16'hA001 + 16'(i)));

        // Reset during bit 7 of a frame with two samples queued
        clear_rx();
        vals = '{16'hFFFF, 16'h1234, 16'h5678};
        push_burst(vals, fb);
        repeat (32) @(posedge clk);
        #2;
        check("midrst pre sdata", sdata_o, 1'b1);
        check("midrst pre busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midrst sdata", sdata_o, 1'b0);
        check("midrst sclk", sclk_o, 1'b0);
        check("midrst fsync", fsync_o, 1'b0);
        check("midrst busy", busy, 1'b0);
        check("midrst in_ready", bus.in_ready, 1'b0);
        repeat (2) @(negedge clk);
        clear_rx();
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("midrst post busy", busy, 1'b0);
        check("midrst post in_ready", bus.in_ready, 1'b1);
        repeat (200) @(posedge clk);
        #1;
        check("midrst no frames", rx_q.size(), 0);
        check("midrst no fsync", fs_q.size(), 0);

        // fir_filter y_out for x = 10,20,30,40,0 with taps {1,-2,3,-1}
        clear_rx();
        vals = '{16'd10, 16'd0, 16'd20, 16'd30, 16'hFFF6};
        push_burst(vals, fb);
        wait_idle(800, "fir");
        check("fir nframes", rx_q.size(), 5);
        check("fir y0", rx_at(0), 32'd10);
        check("fir y1", rx_at(1), 32'd0);
        check("fir y2", rx_at(2), 32'd20);
        check("fir y3", rx_at(3), 32'd30);
        check("fir y4", rx_at(4), 32'h0000_FFF6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
